// File: rtl/spi_register_interface_pkg.sv
// Shared types and constants for the SPI register-write front end.
package spi_register_interface_pkg;

    localparam int unsigned SPI_FRAME_BITS  = 24;
    localparam int unsigned REG_NUMBER_BITS = 16;
    localparam int unsigned REG_VALUE_BITS  = 8;

    typedef logic [REG_NUMBER_BITS-1:0] RegisterNumber_t;
    typedef logic [REG_VALUE_BITS-1:0]  RegisterValue_t;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        TAIL
    } SpiState_t;

endpackage

// File: rtl/spi_register_interface_if.sv
// SPI pins plus the register-write port; slave is the front end, master is the host side.
interface spi_register_interface_if;
    import spi_register_interface_pkg::*;

    logic            i_SPI_SCLK;
    logic            i_SPI_CS_n;
    logic            i_SPI_MOSI;
    logic            o_SPI_MISO;
    logic            o_RegisterWriteEnable;
    RegisterNumber_t o_RegisterWriteNumber;
    RegisterValue_t  o_RegisterWriteValue;
    logic            o_FrameError;

    modport slave (
        input  i_SPI_SCLK,
        input  i_SPI_CS_n,
        input  i_SPI_MOSI,
        output o_SPI_MISO,
        output o_RegisterWriteEnable,
        output o_RegisterWriteNumber,
        output o_RegisterWriteValue,
        output o_FrameError
    );

    modport master (
        output i_SPI_SCLK,
        output i_SPI_CS_n,
        output i_SPI_MOSI,
        input  o_SPI_MISO,
        input  o_RegisterWriteEnable,
        input  o_RegisterWriteNumber,
        input  o_RegisterWriteValue,
        input  o_FrameError
    );

endinterface

// File: rtl/signal_synchronizer.sv
// Single-bit flop-chain synchroniser with a configurable reset value.
module signal_synchronizer #(
    parameter int unsigned STAGES      = 2,
    parameter logic        RESET_VALUE = 1'b0
) (
    input  logic i_Clock,
    input  logic i_Reset_n,
    input  logic i_Async,
    output logic o_Sync
);

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge i_Clock or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            sync_q <= {STAGES{RESET_VALUE}};
        end else begin
            sync_q <= (sync_q << 1) | STAGES'(i_Async);
        end
    end

    assign o_Sync = sync_q[STAGES-1];

endmodule

// File: rtl/spi_register_interface.sv
// SPI mode-0 slave that turns 24-bit {number, value} frames into single-cycle register writes
// and echoes the previously accepted frame on MISO.
module spi_register_interface
    import spi_register_interface_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned FRAME_BITS  = SPI_FRAME_BITS
) (
    input logic                     i_Clock,
    input logic                     i_Reset_n,
    spi_register_interface_if.slave spi_bus
);

    localparam int unsigned            CntBits = $clog2(FRAME_BITS + 2);
    localparam logic [CntBits-1:0]     CntFull = CntBits'(FRAME_BITS);
    localparam logic [CntBits-1:0]     CntSat  = CntBits'(FRAME_BITS + 1);

    logic sclk_s, cs_n_s, mosi_s;
    logic sclk_q, cs_n_q;
    logic sclk_rise, sclk_fall, cs_rise, cs_fall, in_frame;

    SpiState_t              state_q, state_d;
    logic [CntBits-1:0]     cnt_q, cnt_d;
    logic [FRAME_BITS-1:0]  shift_q, shift_d;
    logic [FRAME_BITS-1:0]  tx_q, tx_d;
    logic [FRAME_BITS-1:0]  frame_q, frame_d;
    logic                   pend_q, pend_d;
    logic                   we_q, we_d;
    RegisterNumber_t        num_q, num_d;
    RegisterValue_t         val_q, val_d;
    logic                   err_q, err_d;
    logic                   miso_q, miso_d;

    signal_synchronizer #(
        .STAGES      (SYNC_STAGES),
        .RESET_VALUE (1'b0)
    ) u_sync_sclk (
        .i_Clock   (i_Clock),
        .i_Reset_n (i_Reset_n),
        .i_Async   (spi_bus.i_SPI_SCLK),
        .o_Sync    (sclk_s)
    );

    signal_synchronizer #(
        .STAGES      (SYNC_STAGES),
        .RESET_VALUE (1'b1)
    ) u_sync_cs_n (
        .i_Clock   (i_Clock),
        .i_Reset_n (i_Reset_n),
        .i_Async   (spi_bus.i_SPI_CS_n),
        .o_Sync    (cs_n_s)
    );

    signal_synchronizer #(
        .STAGES      (SYNC_STAGES),
        .RESET_VALUE (1'b0)
    ) u_sync_mosi (
        .i_Clock   (i_Clock),
        .i_Reset_n (i_Reset_n),
        .i_Async   (spi_bus.i_SPI_MOSI),
        .o_Sync    (mosi_s)
    );

    assign sclk_rise = sclk_s & ~sclk_q;
    assign sclk_fall = ~sclk_s & sclk_q;
    assign cs_rise   = cs_n_s & ~cs_n_q;
    assign cs_fall   = ~cs_n_s & cs_n_q;
    // Gate on FSM state rather than live CS_n so a rising SCLK coincident with CS_n release counts.
    assign in_frame  = (state_q != IDLE);

    always_ff @(posedge i_Clock or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            sclk_q  <= 1'b0;
            cs_n_q  <= 1'b1;
            state_q <= IDLE;
            cnt_q   <= '0;
            shift_q <= '0;
            tx_q    <= '0;
            frame_q <= '0;
            pend_q  <= 1'b0;
            we_q    <= 1'b0;
            num_q   <= '0;
            val_q   <= '0;
            err_q   <= 1'b0;
            miso_q  <= 1'b0;
        end else begin
            sclk_q  <= sclk_s;
            cs_n_q  <= cs_n_s;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
            frame_q <= frame_d;
            pend_q  <= pend_d;
            we_q    <= we_d;
            num_q   <= num_d;
            val_q   <= val_d;
            err_q   <= err_d;
            miso_q  <= miso_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shift_d = shift_q;
        tx_d    = tx_q;
        frame_d = frame_q;
        pend_d  = 1'b0;
        we_d    = 1'b0;
        num_d   = num_q;
        val_d   = val_q;
        err_d   = 1'b0;

        // Frame captured last cycle: publish it together with the strobe.
        if (pend_q) begin
            we_d    = 1'b1;
            num_d   = shift_q[FRAME_BITS-1 -: REG_NUMBER_BITS];
            val_d   = shift_q[REG_VALUE_BITS-1:0];
            frame_d = shift_q;
        end

        if (sclk_fall && in_frame) begin
            tx_d = {tx_q[FRAME_BITS-2:0], 1'b0};
        end

        if (sclk_rise && in_frame && (cnt_q != CntSat)) begin
            cnt_d = cnt_q + CntBits'(1);
        end

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (cs_fall) begin
                    state_d = SHIFT;
                    tx_d    = frame_d;
                end
            end
            SHIFT: begin
                if (sclk_rise) begin
                    shift_d = {shift_q[FRAME_BITS-2:0], mosi_s};
                    if (cnt_d == CntFull) begin
                        pend_d  = 1'b1;
                        state_d = TAIL;
                    end
                end
                if (cs_rise) begin
                    err_d   = (cnt_d < CntFull);
                    state_d = IDLE;
                end
            end
            TAIL: begin
                if (cs_rise) begin
                    err_d   = (cnt_d > CntFull);
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        miso_d = (state_d != IDLE) ? tx_d[FRAME_BITS-1] : 1'b0;
    end

    assign spi_bus.o_SPI_MISO            = miso_q;
    assign spi_bus.o_RegisterWriteEnable = we_q;
    assign spi_bus.o_RegisterWriteNumber = num_q;
    assign spi_bus.o_RegisterWriteValue  = val_q;
    assign spi_bus.o_FrameError          = err_q;

endmodule

// File: tb/tb_spi_register_interface.sv
// Directed plus randomised SPI frames checked against a frame-level model of writes, errors and echo.
module tb_spi_register_interface;
    import spi_register_interface_pkg::*;

    localparam int unsigned SyncStages = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    spi_register_interface_if spi_bus ();

    spi_register_interface #(
        .SYNC_STAGES (SyncStages),
        .FRAME_BITS  (24)
    ) dut (
        .i_Clock   (clk),
        .i_Reset_n (rst_n),
        .spi_bus   (spi_bus)
    );

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int rise24_cyc = 0;

    logic [23:0] wr_q[$];
    int          strobe_count = 0;
    int          err_count = 0;
    int          strobe_cyc = 0;
    int          unstable = 0;
    logic [23:0] prev_out = '0;

    // Model state: last accepted frame (echo source) and expected held outputs.
    logic [23:0] model_last = '0;
    logic [23:0] model_out = '0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (spi_bus.o_RegisterWriteEnable) begin
            wr_q.push_back({spi_bus.o_RegisterWriteNumber, spi_bus.o_RegisterWriteValue});
            strobe_count <= strobe_count + 1;
            strobe_cyc   <= cyc;
        end
        if (spi_bus.o_FrameError) err_count <= err_count + 1;
        if (rst_n && !spi_bus.o_RegisterWriteEnable &&
            ({spi_bus.o_RegisterWriteNumber, spi_bus.o_RegisterWriteValue} != prev_out))
            unstable <= unstable + 1;
        prev_out <= {spi_bus.o_RegisterWriteNumber, spi_bus.o_RegisterWriteValue};
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Host side: drives nbits of word MSB first at clk/8 and samples MISO before each rise.
    task automatic spi_frame(input logic [31:0] word, input int nbits, input bit cs_with_last,
                             input int reset_after, output logic [23:0] echo);
        echo = '0;
        @(negedge clk);
        spi_bus.i_SPI_CS_n = 1'b0;
        spi_bus.i_SPI_MOSI = word[nbits-1];
        repeat (4) @(negedge clk);
        for (int i = 0; i < nbits; i++) begin
            if (i < 24) echo = {echo[22:0], spi_bus.o_SPI_MISO};
            spi_bus.i_SPI_SCLK = 1'b1;
            if (i == 23) rise24_cyc = cyc;
            if (cs_with_last && (i == nbits - 1)) spi_bus.i_SPI_CS_n = 1'b1;
            repeat (4) @(negedge clk);
            spi_bus.i_SPI_SCLK = 1'b0;
            if (i + 1 == reset_after) begin
                rst_n = 1'b0;
                spi_bus.i_SPI_CS_n = 1'b1;
                repeat (2) @(negedge clk);
                rst_n = 1'b1;
                repeat (4) @(negedge clk);
                return;
            end
            if (i + 1 < nbits) spi_bus.i_SPI_MOSI = word[nbits-2-i];
            repeat (4) @(negedge clk);
        end
        spi_bus.i_SPI_CS_n = 1'b1;
        repeat (10) @(negedge clk);
    endtask

    task automatic run_frame(input string tag, input logic [31:0] word, input int nbits,
                             input bit cs_with_last);
        int          s0;
        int          e0;
        int          n_seen;
        logic [23:0] echo;
        logic [23:0] exp_frame;
        logic [23:0] got;
        bit          exp_write;
        s0 = strobe_count;
        e0 = err_count;
        spi_frame(word, nbits, cs_with_last, 0, echo);
        n_seen    = (nbits < 24) ? nbits : 24;
        exp_write = (nbits >= 24);
        check({tag, ".echo"}, 32'(echo), 32'(model_last >> (24 - n_seen)));
        check({tag, ".strobes"}, 32'(strobe_count - s0), 32'(exp_write));
        check({tag, ".frame_error"}, 32'(err_count - e0), 32'(nbits != 24));
        if (exp_write) begin
            exp_frame = 24'(word >> (nbits - 24));
            got = (wr_q.size() > 0) ? wr_q.pop_front() : 24'hxxxxxx;
            check({tag, ".write"}, 32'(got), 32'(exp_frame));
            check({tag, ".latency"}, 32'(strobe_cyc - rise24_cyc), 32'(SyncStages + 2));
            model_last = exp_frame;
            model_out  = exp_frame;
        end
        check({tag, ".held"},
              32'({spi_bus.o_RegisterWriteNumber, spi_bus.o_RegisterWriteValue}),
              32'(model_out));
        wr_q.delete();
    endtask

    initial begin
        logic [23:0] echo;
        logic [31:0] word;
        int          nbits;
        int          s0;
        int          e0;
        int          lens[4] = '{13, 24, 24, 25};

        spi_bus.i_SPI_SCLK = 1'b0;
        spi_bus.i_SPI_CS_n = 1'b1;
        spi_bus.i_SPI_MOSI = 1'b0;
        repeat (3) @(negedge clk);
        check("reset.we", 32'(spi_bus.o_RegisterWriteEnable), 32'd0);
        check("reset.num", 32'(spi_bus.o_RegisterWriteNumber), 32'd0);
        check("reset.val", 32'(spi_bus.o_RegisterWriteValue), 32'd0);
        check("reset.err", 32'(spi_bus.o_FrameError), 32'd0);
        check("reset.miso", 32'(spi_bus.o_SPI_MISO), 32'd0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        run_frame("valid", 32'hC0057F, 24, 1'b0);
        run_frame("short", 32'h2A5, 10, 1'b0);
        run_frame("overrun", 32'h2F1E2D3, 26, 1'b0);
        run_frame("echo1", 32'h800001, 24, 1'b0);
        run_frame("echo2", 32'hC12345, 24, 1'b0);
        run_frame("echo3", 32'($urandom) & 32'hFFFFFF, 24, 1'b0);

        s0 = strobe_count;
        e0 = err_count;
        spi_frame(32'hABCDEF, 24, 1'b0, 12, echo);
        model_last = '0;
        model_out  = '0;
        check("rst_mid.strobes", 32'(strobe_count - s0), 32'd0);
        check("rst_mid.err", 32'(err_count - e0), 32'd0);
        check("rst_mid.outputs",
              32'({spi_bus.o_RegisterWriteNumber, spi_bus.o_RegisterWriteValue}), 32'd0);
        check("rst_mid.miso", 32'(spi_bus.o_SPI_MISO), 32'd0);
        run_frame("after_rst", 32'hC300AA, 24, 1'b0);

        run_frame("coincide", 32'($urandom) & 32'hFFFFFF, 24, 1'b1);

        for (int k = 0; k < 6; k++) begin
            nbits = lens[$urandom_range(0, 3)];
            word  = $urandom & ((32'h1 << nbits) - 32'h1);
            run_frame($sformatf("rand%0d", k), word, nbits, 1'b0);
        end

        check("outputs_stable", 32'(unstable), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
